// File: rtl/aes_ct_guard_buf_if.sv
// rtl/aes_ct_guard_buf_if.sv - ciphertext ingress/egress and alarm signal bundle for aes_ct_guard_buf
interface aes_ct_guard_buf_if;
  logic [127:0] ct_i;
  logic         valid_i;
  logic         override_i;
  logic [127:0] ct_o;
  logic         ct_valid_o;
  logic         ct_ready_i;
  logic         clear_i;
  logic         alarm_o;
  logic [7:0]   alarm_cnt_o;
  logic         locked_o;
  logic         drop_o;

  modport slave (
    input  ct_i, valid_i, override_i, ct_ready_i, clear_i,
    output ct_o, ct_valid_o, alarm_o, alarm_cnt_o, locked_o, drop_o
  );

  modport master (
    output ct_i, valid_i, override_i, ct_ready_i, clear_i,
    input  ct_o, ct_valid_o, alarm_o, alarm_cnt_o, locked_o, drop_o
  );
endinterface

// File: rtl/aes_ct_guard_buf.sv
// rtl/aes_ct_guard_buf.sv - ciphertext FIFO that flushes on leak overrides and locks out after repeated events
module aes_ct_guard_buf #(
  parameter int DEPTH       = 2,
  parameter int LOCK_THRESH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  aes_ct_guard_buf_if.slave bus
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [7:0] LT8     = 8'(LOCK_THRESH);

  typedef enum logic [1:0] {ST_RUN, ST_ALARM, ST_LOCKED} state_e;

  state_e       r_state;
  state_e       w_state_nxt;
  logic [127:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [7:0]   r_cnt;
  logic [7:0]   w_cnt_inc;
  logic         r_alarm;
  logic         w_alarm_nxt;
  logic         r_drop;
  logic         w_empty;
  logic         w_full;
  logic         w_pop;
  logic         w_push;
  logic         w_drop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_cnt_inc = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;

  assign w_pop  = !w_empty && bus.ct_ready_i && !bus.override_i;
  assign w_push = bus.valid_i && !bus.override_i && (r_state == ST_RUN) && (!w_full || w_pop);
  assign w_drop = bus.valid_i && !bus.override_i && !w_push;

  always_comb begin
    w_state_nxt = r_state;
    w_alarm_nxt = r_alarm;
    if (bus.override_i) begin
      w_alarm_nxt = 1'b1;
      if ((w_cnt_inc >= LT8) || (r_state == ST_LOCKED)) begin
        w_state_nxt = ST_LOCKED;
      end else begin
        w_state_nxt = ST_ALARM;
      end
    end else if ((r_state == ST_ALARM) && bus.clear_i) begin
      w_state_nxt = ST_RUN;
      w_alarm_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_RUN;
      r_alarm <= 1'b0;
      r_drop  <= 1'b0;
      r_cnt   <= 8'd0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_alarm <= w_alarm_nxt;
      r_drop  <= w_drop;
      if (bus.override_i) begin
        // A leak indication scrubs every buffered word, including one being popped.
        r_cnt  <= w_cnt_inc;
        r_wptr <= '0;
        r_rptr <= '0;
        for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
        if (w_pop) r_rptr <= r_rptr + PTR_ONE;
        if (w_push) begin
          r_mem[r_wptr[AW-1:0]] <= bus.ct_i;
          r_wptr                <= r_wptr + PTR_ONE;
        end
      end
    end
  end

  assign bus.ct_o        = w_empty ? 128'h0 : r_mem[r_rptr[AW-1:0]];
  assign bus.ct_valid_o  = !w_empty;
  assign bus.alarm_o     = r_alarm;
  assign bus.alarm_cnt_o = r_cnt;
  assign bus.locked_o    = (r_state == ST_LOCKED);
  assign bus.drop_o      = r_drop;
endmodule

// File: doc/aes_ct_guard_buf.md
AES_CT_GUARD_BUF -- requirements
Module: aes_ct_guard_buf

Interface
REQ-001 Parameter: DEPTH, 2, number of ciphertext entries held; power of two, 2..8.
REQ-002 Parameter: LOCK_THRESH, 4, override count that forces permanent lockout; 1..255.
REQ-003 Port: clk_i  input  1  single clock; all state on rising edge.
REQ-004 Port: rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: ct_i  input  128  ciphertext from the pt/ct leak monitor stage.
REQ-006 Port: valid_i  input  1  monitor-gated ciphertext valid.
REQ-007 Port: override_i  input  1  monitor leak indication (ct equals pt).
REQ-008 Port: ct_o  output  128  head-of-buffer ciphertext to consumer.
REQ-009 Port: ct_valid_o  output  1  head entry valid.
REQ-010 Port: ct_ready_i  input  1  consumer accepts head entry.
REQ-011 Port: clear_i  input  1  software alarm acknowledge, single-cycle pulse.
REQ-012 Port: alarm_o  output  1  sticky alarm flag.
REQ-013 Port: alarm_cnt_o  output  8  override event count, saturating.
REQ-014 Port: locked_o  output  1  lockout state indicator.
REQ-015 Port: drop_o  output  1  one-cycle pulse: valid ciphertext discarded.

Function
REQ-016 The block SHALL hold a DEPTH-entry FIFO; ct_valid_o SHALL be 1 iff FIFO non-empty; ct_o SHALL equal the head entry when non-empty and 128'h0 when empty.
REQ-017 Pop SHALL occur when ct_valid_o && ct_ready_i; the next entry (or zero) SHALL appear on ct_o the following cycle.
REQ-018 Push SHALL occur when valid_i && !override_i && state==RUN && (not full || pop same cycle); data visible on ct_o no earlier than the cycle after push (1-cycle latency).
REQ-019 A push qualifier met except for a full FIFO without pop SHALL drop the word and pulse drop_o for one cycle; pointers unchanged.
REQ-020 Valid_i in ALARM or LOCKED SHALL be discarded with drop_o pulsed.
REQ-021 Pointers SHALL wrap modulo DEPTH; full/empty distinguished by an extra pointer bit or occupancy counter.
REQ-022 State machine: RUN, ALARM, LOCKED.
REQ-023 RUN->ALARM on any cycle with override_i=1, regardless of valid_i.
REQ-024 ALARM->RUN on clear_i=1 with override_i=0 in that cycle.
REQ-025 RUN or ALARM ->LOCKED when the post-increment alarm_cnt_o value >= LOCK_THRESH; LOCKED exited only by reset; clear_i ignored in LOCKED.
REQ-026 Each cycle with override_i=1 SHALL increment alarm_cnt_o by 1, saturating at 255, in any state.
REQ-027 Each override_i=1 cycle SHALL flush the FIFO (all entries invalid, storage zeroed) next edge; simultaneous pop SHALL be squashed; simultaneous valid_i SHALL not push and SHALL not pulse drop_o.
REQ-028 alarm_o SHALL set the cycle after override_i and clear only on accepted ALARM->RUN transition; locked_o=1 iff state==LOCKED.
REQ-029 Simultaneous clear_i and override_i: override SHALL win (stay/enter ALARM or LOCKED, count increments).
REQ-030 alarm_cnt_o SHALL not be cleared by clear_i; only reset clears it.

Reset
REQ-031 rst_ni=0 SHALL immediately force: state RUN, FIFO empty, storage zero, ct_o=0, ct_valid_o=0, alarm_o=0, alarm_cnt_o=0, locked_o=0, drop_o=0.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered data; first push after deassertion lands in entry 0.

Verification
REQ-033 Push A, B with ct_ready_i=0, then valid C -> ct_o=A, ct_valid_o=1, drop_o pulse on C; ready=1 two cycles -> A then B, then ct_valid_o=0, ct_o=0.
REQ-034 Full FIFO, valid_i and ct_ready_i same cycle -> pop A, push C accepted, no drop_o.
REQ-035 Two entries buffered, override_i one cycle -> next cycle ct_valid_o=0, alarm_o=1, alarm_cnt_o=1, state ALARM; valid_i then -> drop_o; clear_i -> alarm_o=0, pushes resume.
REQ-036 LOCK_THRESH=4: four override pulses with clear_i between -> locked_o=1 after fourth; clear_i ignored; only rst_ni=0 returns locked_o=0, alarm_cnt_o=0.
REQ-037 clear_i and override_i in same ALARM cycle -> alarm_o stays 1, alarm_cnt_o +1.
REQ-038 300 override cycles, LOCK_THRESH=255 -> alarm_cnt_o saturates at 255, locked_o=1.
